// File: rtl/video_tone_pkg.sv
// video_tone_pkg -- shared constants and types for the video tone mapper.
//   LUMA_R/G/B   : 8-bit fixed-point luma weights (sum to 255, scaled by 256)
//   LUMA_ROUND   : rounding constant added before the >>8
//   tint_e       : tint encodings carried in mode bits[1:0]
//   mode_t       : packed view of the 3-bit mode word (dim flag + tint)
//   bayer()      : 2x2 ordered-dither matrix [[0,2],[3,1]] indexed
//                  [line parity][pixel parity]
package video_tone_pkg;

    localparam int LUMA_R     = 54;
    localparam int LUMA_G     = 183;
    localparam int LUMA_B     = 18;
    localparam int LUMA_SHIFT = 8;
    localparam int LUMA_ROUND = 128;

    typedef enum logic [1:0] {
        TINT_COLOUR = 2'd0,
        TINT_GREEN  = 2'd1,
        TINT_AMBER  = 2'd2,
        TINT_WHITE  = 2'd3
    } tint_e;

    typedef struct packed {
        logic  dim;
        tint_e tint;
    } mode_t;

    function automatic logic [1:0] bayer(input logic line_par, input logic pix_par);
        logic [1:0] m;
        case ({line_par, pix_par})
            2'b00:   m = 2'd0;
            2'b01:   m = 2'd2;
            2'b10:   m = 2'd3;
            default: m = 2'd1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tone_quantizer.sv
// tone_quantizer -- reduces one colour component from IN_W to OUT_W bits.
// Build option: define TONE_DITHER_EN to add a 2x2 Bayer offset
// (m << (IN_W-OUT_W-2), saturating at 2^IN_W-1) before truncation; this
// needs IN_W-OUT_W >= 2. Without it the component is truncated plainly.
// Ports:
//   comp_i     : component at IN_W bits
//   line_par_i : line parity of this pixel (dither row select)
//   pix_par_i  : pixel parity of this pixel (dither column select)
//   comp_o     : component at OUT_W bits (combinational)
module tone_quantizer
    import video_tone_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int OUT_W = 3
) (
    input  logic [IN_W-1:0]  comp_i,
    input  logic             line_par_i,
    input  logic             pix_par_i,
    output logic [OUT_W-1:0] comp_o
);

`ifdef TONE_DITHER_EN
    localparam int DROP = IN_W - OUT_W;

    // One spare bit catches the carry so saturation can be detected.
    logic [IN_W:0]   dith_sum;
    logic [IN_W-1:0] dith_sat;
    logic [DROP-1:0] unused_lsb;

    always_comb begin
        dith_sum = {1'b0, comp_i} + ((IN_W + 1)'(bayer(line_par_i, pix_par_i)) << (DROP - 2));
        dith_sat = dith_sum[IN_W] ? '1 : dith_sum[IN_W-1:0];
    end

    assign comp_o     = dith_sat[IN_W-1 -: OUT_W];
    assign unused_lsb = dith_sat[DROP-1:0];
`else
    logic unused_par;
    assign unused_par = line_par_i ^ pix_par_i;

    generate
        if (IN_W > OUT_W) begin : g_trunc
            logic [IN_W-OUT_W-1:0] unused_lsb;
            assign comp_o     = comp_i[IN_W-1 -: OUT_W];
            assign unused_lsb = comp_i[IN_W-OUT_W-1:0];
        end else begin : g_pass
            assign comp_o = comp_i;
        end
    endgenerate
`endif

endmodule

// File: rtl/video_tone_mapper.sv
// video_tone_mapper -- 3-stage pixel pipeline: luma, tint, scanline dim and
// quantisation from IN_W to OUT_W bits per component.
// Build option: TONE_DITHER_EN enables ordered dithering in the quantizers.
// Ports:
//   clk_vga                  : pixel clock
//   rst_n                    : asynchronous active-low reset
//   r_i/g_i/b_i              : source pixel, IN_W bits per component
//   de_i, hsync_i, vsync_i   : data enable (active high), syncs (active low)
//   mode_i                   : [1:0] tint (colour/green/amber/white), [2] scanline dim
//   r_o/g_o/b_o              : output pixel, OUT_W bits, zero when de_o is low
//   de_o, hsync_o, vsync_o   : controls delayed by the same 3 cycles as the pixel
//   mode_o                   : mode applied to the pixel currently on the outputs
// Stage 1 registers the weighted products and the raw pixel. Between stages 1
// and 2 the frame/line/pixel state (active mode, parities) is resolved for the
// pixel in stage 1 and then travels down the pipe with it, so no stage ever
// mixes state from different pixels.
module video_tone_mapper
    import video_tone_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int OUT_W = 3
) (
    input  logic             clk_vga,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  r_i,
    input  logic [IN_W-1:0]  g_i,
    input  logic [IN_W-1:0]  b_i,
    input  logic             de_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [2:0]       mode_i,
    output logic [OUT_W-1:0] r_o,
    output logic [OUT_W-1:0] g_o,
    output logic [OUT_W-1:0] b_o,
    output logic             de_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic [2:0]       mode_o
);

    // The weighted sum is at most 255*(2^IN_W-1)+128, which fits in IN_W+8 bits.
    localparam int PW = IN_W + LUMA_SHIFT;

    // ---------------- stage 1 ----------------
    logic [PW-1:0]        s1_pr, s1_pg, s1_pb;
    logic [2:0][IN_W-1:0] s1_c;
    logic                 s1_de, s1_hs, s1_vs;
    mode_t                s1_mode;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            s1_pr   <= '0;
            s1_pg   <= '0;
            s1_pb   <= '0;
            s1_c    <= '0;
            s1_de   <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_mode <= '0;
        end else begin
            s1_pr   <= PW'(r_i) * PW'(LUMA_R);
            s1_pg   <= PW'(g_i) * PW'(LUMA_G);
            s1_pb   <= PW'(b_i) * PW'(LUMA_B);
            s1_c    <= {b_i, g_i, r_i};
            s1_de   <= de_i;
            s1_hs   <= hsync_i;
            s1_vs   <= vsync_i;
            s1_mode <= mode_t'(mode_i);
        end
    end

    // ---------------- frame / line state ----------------
    // Stage-2 syncs hold the previous stage-1 syncs, so they double as the
    // edge-detect history.
    logic  s2_de, s2_hs, s2_vs;
    mode_t s2_mode;
    logic  s2_pix_par, s2_line_par;

    mode_t active_mode, pix_mode;
    logic  pix_par, line_par;
    logic  pix_par_cur, line_par_cur;
    logic  vs_fall, hs_fall;

    always_comb begin
        vs_fall      = s2_vs & ~s1_vs;
        hs_fall      = s2_hs & ~s1_hs;
        // A new mode takes effect starting with the pixel that carries the
        // vsync falling edge.
        pix_mode     = vs_fall ? s1_mode : active_mode;
        pix_par_cur  = hs_fall ? 1'b0 : pix_par;
        // vsync clear has priority over the hsync toggle.
        line_par_cur = vs_fall ? 1'b0 : (hs_fall ? ~line_par : line_par);
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            active_mode <= '0;
            pix_par     <= 1'b0;
            line_par    <= 1'b0;
        end else begin
            active_mode <= pix_mode;
            pix_par     <= pix_par_cur ^ s1_de;
            line_par    <= line_par_cur;
        end
    end

    // ---------------- stage 2: luma, tint, dim ----------------
    logic [PW-1:0]        luma_sum;
    logic [IN_W-1:0]      luma;
    logic [LUMA_SHIFT-1:0] unused_luma_lsb;
    logic [2:0][IN_W-1:0] tint_c, dim_c;
    logic                 dim_en;

    assign luma_sum        = s1_pr + s1_pg + s1_pb + PW'(LUMA_ROUND);
    assign luma            = luma_sum[PW-1 -: IN_W];
    assign unused_luma_lsb = luma_sum[LUMA_SHIFT-1:0];
    assign dim_en          = pix_mode.dim & line_par_cur;

    always_comb begin
        tint_c = '0;
        case (pix_mode.tint)
            TINT_COLOUR: tint_c = s1_c;
            TINT_GREEN:  tint_c = {{IN_W{1'b0}}, luma, {IN_W{1'b0}}};
            TINT_AMBER:  tint_c = {{IN_W{1'b0}}, luma >> 1, luma};
            TINT_WHITE:  tint_c = {luma, luma, luma};
            default:     tint_c = '0;
        endcase
    end

    logic [2:0][IN_W-1:0] s2_c;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            s2_c        <= '0;
            s2_de       <= 1'b0;
            s2_hs       <= 1'b1;
            s2_vs       <= 1'b1;
            s2_mode     <= '0;
            s2_pix_par  <= 1'b0;
            s2_line_par <= 1'b0;
        end else begin
            s2_c        <= dim_c;
            s2_de       <= s1_de;
            s2_hs       <= s1_hs;
            s2_vs       <= s1_vs;
            s2_mode     <= pix_mode;
            s2_pix_par  <= pix_par_cur;
            s2_line_par <= line_par_cur;
        end
    end

    // ---------------- stage 3: quantise ----------------
    logic [2:0][OUT_W-1:0] q_c;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_comp
            assign dim_c[gi] = dim_en ? (tint_c[gi] >> 1) : tint_c[gi];

            tone_quantizer #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W)
            ) u_quant (
                .comp_i     (s2_c[gi]),
                .line_par_i (s2_line_par),
                .pix_par_i  (s2_pix_par),
                .comp_o     (q_c[gi])
            );
        end
    endgenerate

    logic [2:0][OUT_W-1:0] s3_c;
    logic                  s3_de, s3_hs, s3_vs;
    mode_t                 s3_mode;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            s3_c    <= '0;
            s3_de   <= 1'b0;
            s3_hs   <= 1'b1;
            s3_vs   <= 1'b1;
            s3_mode <= '0;
        end else begin
            s3_c    <= s2_de ? q_c : '0;
            s3_de   <= s2_de;
            s3_hs   <= s2_hs;
            s3_vs   <= s2_vs;
            s3_mode <= s2_mode;
        end
    end

    assign r_o     = s3_c[0];
    assign g_o     = s3_c[1];
    assign b_o     = s3_c[2];
    assign de_o    = s3_de;
    assign hsync_o = s3_hs;
    assign vsync_o = s3_vs;
    assign mode_o  = s3_mode;

endmodule

// File: tb/tb_video_tone_mapper.sv
// tb_video_tone_mapper -- scoreboard bench for video_tone_mapper (IN_W=6,
// OUT_W=3). Each driven cycle pushes the expected output computed by a small
// behavioural model; the entry is popped and compared three cycles later.
// Follows TONE_DITHER_EN the same way the design does.
module tb_video_tone_mapper;

    localparam int IN_W  = 6;
    localparam int OUT_W = 3;
    localparam int CMAX  = (1 << IN_W) - 1;

    logic             clk_vga = 1'b0;
    logic             rst_n   = 1'b0;
    logic [IN_W-1:0]  r_i = '0, g_i = '0, b_i = '0;
    logic             de_i = 1'b0, hsync_i = 1'b1, vsync_i = 1'b1;
    logic [2:0]       mode_i = '0;
    logic [OUT_W-1:0] r_o, g_o, b_o;
    logic             de_o, hsync_o, vsync_o;
    logic [2:0]       mode_o;

    always #5 clk_vga = ~clk_vga;

    video_tone_mapper #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk_vga (clk_vga),
        .rst_n   (rst_n),
        .r_i     (r_i),
        .g_i     (g_i),
        .b_i     (b_i),
        .de_i    (de_i),
        .hsync_i (hsync_i),
        .vsync_i (vsync_i),
        .mode_i  (mode_i),
        .r_o     (r_o),
        .g_o     (g_o),
        .b_o     (b_o),
        .de_o    (de_o),
        .hsync_o (hsync_o),
        .vsync_o (vsync_o),
        .mode_o  (mode_o)
    );

    typedef struct {
        int id;
        int r, g, b;
        int de, hs, vs;
        int mode;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn      = 0;

    // reference model state
    int m_prev_hs, m_prev_vs, m_mode, m_pix, m_line;
    int bay [2][2] = '{'{0, 2}, '{3, 1}};

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_prev_hs = 1;
        m_prev_vs = 1;
        m_mode    = 0;
        m_pix     = 0;
        m_line    = 0;
    endtask

    function automatic int quant(input int c, input int lp, input int pp);
        int v;
        v = c;
`ifdef TONE_DITHER_EN
        v = c + (bay[lp][pp] << (IN_W - OUT_W - 2));
        if (v > CMAX) v = CMAX;
`endif
        return v >> (IN_W - OUT_W);
    endfunction

    // One cycle: compare the oldest expectation if due, then drive and predict.
    task automatic drive(input int r, input int g, input int b,
                         input int de, input int hs, input int vs);
        exp_t o, e;
        int   vf, hf, pp, lp, y;
        int   c[3];
        @(negedge clk_vga);
        if (sb.size() == 3) begin
            o = sb.pop_front();
            $display("txn %0d: rgb=(%0d,%0d,%0d) de=%0d hs=%0d vs=%0d mode=%0d | want (%0d,%0d,%0d) mode=%0d",
                     o.id, r_o, g_o, b_o, de_o, hsync_o, vsync_o, mode_o, o.r, o.g, o.b, o.mode);
            check_eq("r_o", int'(r_o), o.r);
            check_eq("g_o", int'(g_o), o.g);
            check_eq("b_o", int'(b_o), o.b);
            check_eq("de_o", int'(de_o), o.de);
            check_eq("hsync_o", int'(hsync_o), o.hs);
            check_eq("vsync_o", int'(vsync_o), o.vs);
            check_eq("mode_o", int'(mode_o), o.mode);
        end
        r_i     = IN_W'(r);
        g_i     = IN_W'(g);
        b_i     = IN_W'(b);
        de_i    = de[0];
        hsync_i = hs[0];
        vsync_i = vs[0];

        vf = (m_prev_vs == 1 && vs == 0) ? 1 : 0;
        hf = (m_prev_hs == 1 && hs == 0) ? 1 : 0;
        if (vf == 1) m_mode = int'(mode_i);
        pp = (hf == 1) ? 0 : m_pix;
        lp = (vf == 1) ? 0 : ((hf == 1) ? 1 - m_line : m_line);
        m_pix     = (de != 0) ? 1 - pp : pp;
        m_line    = lp;
        m_prev_vs = vs;
        m_prev_hs = hs;

        y = (54 * r + 183 * g + 18 * b + 128) >> 8;
        case (m_mode & 3)
            0:       begin c[0] = r; c[1] = g;      c[2] = b; end
            1:       begin c[0] = 0; c[1] = y;      c[2] = 0; end
            2:       begin c[0] = y; c[1] = y >> 1; c[2] = 0; end
            default: begin c[0] = y; c[1] = y;      c[2] = y; end
        endcase
        if ((m_mode & 4) != 0 && lp == 1) begin
            for (int k = 0; k < 3; k++) c[k] = c[k] >> 1;
        end

        e.id   = txn;
        e.r    = (de != 0) ? quant(c[0], lp, pp) : 0;
        e.g    = (de != 0) ? quant(c[1], lp, pp) : 0;
        e.b    = (de != 0) ? quant(c[2], lp, pp) : 0;
        e.de   = de;
        e.hs   = hs;
        e.vs   = vs;
        e.mode = m_mode;
        sb.push_back(e);
        txn++;
    endtask

    task automatic pix(input int r, input int g, input int b);
        drive(r, g, b, 1, 1, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 1);
    endtask

    // vsync and hsync fall together: new frame, line parity 0, mode sampled.
    task automatic frame_start(input int mode);
        mode_i = 3'(mode);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
    endtask

    task automatic line_break();
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " r_o"}, int'(r_o), 0);
        check_eq({tag, " g_o"}, int'(g_o), 0);
        check_eq({tag, " b_o"}, int'(b_o), 0);
        check_eq({tag, " de_o"}, int'(de_o), 0);
        check_eq({tag, " hsync_o"}, int'(hsync_o), 1);
        check_eq({tag, " vsync_o"}, int'(vsync_o), 1);
        check_eq({tag, " mode_o"}, int'(mode_o), 0);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_vga);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // colour mode, primary and mixed pixels
        idle(2);
        frame_start(0);
        pix(63, 0, 0);
        pix(0, 63, 0);
        pix(0, 0, 63);
        pix(17, 40, 9);
        idle(1);
        line_break();
        pix(4, 0, 0);
        pix(4, 0, 0);
        pix(63, 63, 63);

        // green and amber tints
        frame_start(1);
        pix(63, 63, 63);
        pix(10, 50, 30);
        frame_start(2);
        pix(32, 32, 32);
        pix(5, 60, 2);

        // mid-frame mode change is deferred to the next frame
        frame_start(0);
        pix(40, 20, 10);
        mode_i = 3'd3;
        pix(40, 20, 10);
        line_break();
        pix(40, 20, 10);
        frame_start(3);
        pix(40, 20, 10);
        pix(63, 0, 0);

        // scanline dim: line 0 full, line 1 halved
        frame_start(4);
        pix(63, 0, 0);
        pix(63, 0, 0);
        line_break();
        pix(63, 0, 0);
        pix(63, 0, 0);
        pix(4, 0, 0);
        pix(4, 0, 0);
        line_break();
        pix(63, 0, 0);

        // dither positions in colour mode
        frame_start(0);
        pix(4, 0, 0);
        pix(4, 0, 0);
        line_break();
        pix(4, 0, 0);
        pix(4, 0, 0);
        pix(63, 63, 63);
        pix(63, 63, 63);

        // random frames with random mid-frame mode changes
        for (int f = 0; f < 3; f++) begin
            frame_start(int'($urandom_range(0, 7)));
            for (int l = 0; l < 3; l++) begin
                for (int p = 0; p < 6; p++) begin
                    if ($urandom_range(0, 7) == 0) mode_i = 3'($urandom_range(0, 7));
                    drive(int'($urandom_range(0, CMAX)), int'($urandom_range(0, CMAX)),
                          int'($urandom_range(0, CMAX)), int'($urandom_range(0, 4) != 0), 1, 1);
                end
                line_break();
            end
        end

        // reset in the middle of a bright white line
        frame_start(3);
        pix(63, 63, 63);
        pix(50, 50, 50);
        pix(63, 63, 63);
        @(posedge clk_vga);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midline_rst");
        model_reset();
        r_i     = '0;
        g_i     = '0;
        b_i     = '0;
        de_i    = 1'b0;
        hsync_i = 1'b1;
        vsync_i = 1'b1;
        mode_i  = 3'd0;
        repeat (2) @(negedge clk_vga);
        check_reset_outputs("held_rst");
        rst_n = 1'b1;

        // first pixel after reset: colour mode, exactly three cycles of latency
        pix(63, 0, 0);
        pix(0, 0, 63);
        idle(1);
        line_break();
        pix(63, 63, 0);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
